// File: rtl/spi_flash_tl_bridge.sv
// spi_flash_tl_bridge: TileLink-UL Get -> SPI flash byte-read PHY bridge.
// Each legal Get becomes 1, 2 or 4 single-byte PHY reads. The bytes are packed
// little-endian into a 32-bit beat by address lane. Writes and malformed requests
// get a denied response and never reach the PHY.
//
// Handshakes: an A beat transfers on a clock edge where a_valid & a_ready are
// both high. A D beat transfers on an edge where d_valid & d_ready are both high.
// Once d_valid rises, every d_* field holds steady until that transfer.
module spi_flash_tl_bridge #(
    parameter int SOURCE_W = 4
) (
    input  logic                lsioc_clk_i,
    input  logic                lsioc_rst_i,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [1:0]          a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [23:0]         a_address,
    input  logic [3:0]          a_mask,
    input  logic [31:0]         a_data,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic                d_denied,
    output logic [31:0]         d_data,
    output logic [23:0]         spi_rd_addr_o,
    output logic                rd_o,
    input  logic                busy_i,
    input  logic [7:0]          data_i,
    input  logic                data_vld_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [23:0]           ptr_q, ptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  vld_q;
    logic [2:0]            d_opcode_q, d_opcode_d;
    logic [1:0]            d_size_q, d_size_d;
    logic [SOURCE_W-1:0]   d_source_q, d_source_d;
    logic                  d_denied_q, d_denied_d;
    logic [31:0]           d_data_q, d_data_d;

    logic aligned;
    logic legal;
    logic vld_edge;
    logic unused_inputs;

    // Write-data fields carry nothing for a read-only device.
    assign unused_inputs = ^{a_param, a_mask, a_data};

    // Natural alignment check; a size of 3 (8 bytes) is never legal.
    always_comb begin
        aligned = 1'b0;
        case (a_size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~a_address[0];
            2'd2:    aligned = (a_address[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign legal    = (a_opcode == 3'd4) && aligned;
    assign vld_edge = data_vld_i & ~vld_q;

    // Next-state and response-field computation for the request FSM.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        d_opcode_d = d_opcode_q;
        d_size_d   = d_size_q;
        d_source_d = d_source_q;
        d_denied_d = d_denied_q;
        d_data_d   = d_data_q;
        case (state_q)
            IDLE: begin
                if (a_valid) begin
                    d_opcode_d = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
                    d_size_d   = a_size;
                    d_source_d = a_source;
                    d_denied_d = ~legal;
                    d_data_d   = 32'd0;
                    ptr_d      = a_address;
                    case (a_size)
                        2'd0:    cnt_d = 2'd0;
                        2'd1:    cnt_d = 2'd1;
                        default: cnt_d = 2'd3;
                    endcase
                    state_d = legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                if (!busy_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (vld_edge) begin
                    case (ptr_q[1:0])
                        2'd0:    d_data_d[7:0]   = data_i;
                        2'd1:    d_data_d[15:8]  = data_i;
                        2'd2:    d_data_d[23:16] = data_i;
                        default: d_data_d[31:24] = data_i;
                    endcase
                    ptr_d = ptr_q + 24'd1;
                    if (cnt_q == 2'd0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = cnt_q - 2'd1;
                        state_d = ISSUE;
                    end
                end
            end
            default: begin
                if (d_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State, pointer, counter, response fields and PHY valid edge register.
    always_ff @(posedge lsioc_clk_i) begin
        if (lsioc_rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= 24'd0;
            cnt_q      <= 2'd0;
            vld_q      <= 1'b0;
            d_opcode_q <= 3'd0;
            d_size_q   <= 2'd0;
            d_source_q <= '0;
            d_denied_q <= 1'b0;
            d_data_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            vld_q      <= data_vld_i;
            d_opcode_q <= d_opcode_d;
            d_size_q   <= d_size_d;
            d_source_q <= d_source_d;
            d_denied_q <= d_denied_d;
            d_data_q   <= d_data_d;
        end
    end

    assign a_ready       = (state_q == IDLE);
    assign d_valid       = (state_q == RESP);
    assign rd_o          = (state_q == ISSUE) && !busy_i;
    assign spi_rd_addr_o = ptr_q;
    assign d_opcode      = d_opcode_q;
    assign d_size        = d_size_q;
    assign d_source      = d_source_q;
    assign d_denied      = d_denied_q;
    assign d_data        = d_data_q;

endmodule

// File: doc/spi_flash_tl_bridge.md
# spi_flash_tl_bridge

Bridges the low-speed I/O TileLink-UL bus to the SPI flash byte-read PHY. It accepts one TileLink Get at a time and turns it into 1, 2 or 4 sequential single-byte flash reads. It assembles the bytes little-endian into a 32-bit beat and returns AccessAckData. The flash is read-only, so writes and malformed requests are answered with a denied AccessAck and never touch the PHY.

## Interface
- SOURCE_W, 4, width of a_source/d_source
- lsioc_clk_i  in  1  sole clock
- lsioc_rst_i  in  1  synchronous, active-high reset
- a_valid  in  1  TL-A request valid
- a_ready  out  1  TL-A ready; high only in IDLE
- a_opcode  in  3  4=Get, 0=PutFull, 1=PutPartial; others illegal
- a_param  in  3  ignored
- a_size  in  2  log2 bytes
- a_source  in  SOURCE_W  request ID
- a_address  in  24  byte address
- a_mask  in  4  ignored for Get
- a_data  in  32  ignored
- d_valid  out  1  TL-D response valid
- d_ready  in  1  TL-D ready
- d_opcode  out  3  1=AccessAckData (Get), 0=AccessAck (others)
- d_size  out  2  echo of a_size
- d_source  out  SOURCE_W  echo of a_source
- d_denied  out  1  request refused
- d_data  out  32  read data; 0 when denied or for AccessAck
- spi_rd_addr_o  out  24  byte address to PHY
- rd_o  out  1  one-cycle PHY read strobe
- busy_i  in  1  PHY busy
- data_i  in  8  PHY read byte
- data_vld_i  in  1  PHY byte valid (level)

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: a_ready=1. When a_valid is high, the request is latched: opcode, size, source and address.
  - Go to ISSUE if the request is legal: opcode=4, a_size≤2, and a_address aligned to 2^a_size.
  - Otherwise go to RESP with d_denied=1 and d_data=0.
  - d_opcode=1 for any Get (including denied ones); d_opcode=0 for every other opcode.
- Byte count = 2^a_size. A 2-bit remaining counter is loaded with count−1. The byte pointer starts at a_address.
- ISSUE: when busy_i=0, rd_o=1 for exactly that cycle, then go to WAIT. While busy_i=1, stay in ISSUE with rd_o=0. rd_o is combinational from state and busy_i. spi_rd_addr_o is registered and holds the byte pointer throughout ISSUE and WAIT.
- WAIT: a byte is accepted only on a data_vld_i rising edge, i.e. data_vld_i=1 and the registered previous value is 0.
  - Store data_i into the d_data lane given by pointer[1:0]: lane k = bits 8k+7:8k.
  - Increment the pointer by 1, with 24-bit wrap.
  - If the counter is 0, go to RESP. Otherwise decrement the counter and go to ISSUE.
- d_data is cleared to 0 on request acceptance, so lanes not read stay 0.
- RESP: d_valid=1, and all d_* fields stay stable until d_ready. On d_valid & d_ready, go to IDLE.
- Edge-detect register runs in all states. A rising edge seen outside WAIT is discarded.

## Timing
- Reset values:
  - Outputs: a_ready=1, d_valid=0, d_denied=0, d_opcode=0, d_size=0, d_source=0, d_data=0, rd_o=0, spi_rd_addr_o=0.
  - Internal: state=IDLE, edge register=0.
- Acceptance to first rd_o: 1 cycle, if busy_i=0.
- Per byte: ISSUE (≥1 cycle) + WAIT (until the PHY edge) + 1 cycle for the capture transition.
- Last byte capture to d_valid: next cycle.
- Denied request: d_valid rises the cycle after acceptance. No rd_o is ever asserted for it.
- Only one request is outstanding at a time. a_ready=0 from the cycle after acceptance until RESP completes.
- d_ready held low: stay in RESP indefinitely; no new A beat is accepted.
- Reset mid-operation: the next clock returns to IDLE and drops d_valid and rd_o. A later PHY data_vld_i edge is ignored. The next request waits in ISSUE for busy_i=0.
- Address 0xFFFFFF read: not reachable for multi-byte requests, because alignment forces the low bits to 0. Pointer wrap is defined for completeness.

## Test plan
- Get size 0 at 0x000103; PHY returns 0xA5 → one rd_o with spi_rd_addr_o=0x000103. Response: d_opcode=1, d_data=0xA5000000, d_denied=0.
- Get size 2 at 0x001000; bytes 11,22,33,44 → four rd_o strobes at 0x1000–0x1003, each only while busy_i=0. Response: d_data=0x44332211, d_size=2, d_source echoed.
- Get size 1 at 0x000001 (misaligned) → no rd_o. Next cycle: d_valid, d_denied=1, d_opcode=1, d_data=0.
- PutFull size 2 at 0x0 → no rd_o. Response: d_opcode=0, d_denied=1. Also Get with a_size=3 → denied.
- Size 2 Get with d_ready low for 10 cycles after d_valid → d_* stable throughout; a_ready=0 until the handshake, then 1 the next cycle.
- Assert lsioc_rst_i while in WAIT on byte 2, then issue a new size 0 Get with busy_i held high for 5 cycles → stale data_vld_i edge ignored. rd_o is asserted only after busy_i falls, and correct data is returned.
